// File: rtl/adder_top.sv
// Registered 4-bit ripple-carry adder/subtractor for the switch/LED board demo.
// Result and operands are snapshotted together so LEDR and HEX always agree.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module adder_top (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [9:0] SW,
   output logic [4:0] LEDR,
   output logic [6:0] HEX0,
   output logic [6:0] HEX1,
   output logic [6:0] HEX2,
   output logic [6:0] HEX3,
   output logic [6:0] HEX4,
   output logic [6:0] HEX5
);
   localparam logic [6:0] SEG_ZERO  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   logic       sub;
   logic [3:0] a;
   logic [3:0] b;
   logic [3:0] b_eff;
   logic [3:0] s;
   logic [4:0] c;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] seg;
      case (v)
         4'h0:    seg = 7'h40;
         4'h1:    seg = 7'h79;
         4'h2:    seg = 7'h24;
         4'h3:    seg = 7'h30;
         4'h4:    seg = 7'h19;
         4'h5:    seg = 7'h12;
         4'h6:    seg = 7'h02;
         4'h7:    seg = 7'h78;
         4'h8:    seg = 7'h00;
         4'h9:    seg = 7'h10;
         4'hA:    seg = 7'h08;
         4'hB:    seg = 7'h03;
         4'hC:    seg = 7'h46;
         4'hD:    seg = 7'h21;
         4'hE:    seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

   assign sub   = SW[9];
   assign a     = SW[7:4];
   assign b     = SW[3:0];
   assign b_eff = b ^ {4{sub}};
   // subtract forces carry-in high to complete the two's complement of B
   assign c[0]  = sub | SW[8];

   for (genvar i = 0; i < 4; i++) begin : g_rca
      full_adder u_fa (
         .a  (a[i]),
         .b  (b_eff[i]),
         .ci (c[i]),
         .s  (s[i]),
         .co (c[i+1])
      );
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         LEDR <= '0;
         HEX0 <= SEG_ZERO;
         HEX1 <= SEG_ZERO;
         HEX2 <= SEG_ZERO;
         HEX3 <= SEG_ZERO;
         HEX4 <= SEG_BLANK;
         HEX5 <= SEG_BLANK;
      end else begin
         LEDR <= {c[4], s};
         HEX0 <= hex7(b);
         HEX1 <= hex7(a);
         HEX2 <= hex7(s);
         HEX3 <= hex7({3'b000, c[4]});
         HEX4 <= SEG_BLANK;
         HEX5 <= SEG_BLANK;
      end
   end
endmodule

// File: tb/tb_adder_top.sv
// Self-checking bench for adder_top: directed, latency, exhaustive
// and random steps against an arithmetic reference model.
module tb_adder_top;
   logic       CLOCK_50 = 1'b0;
   logic       reset    = 1'b1;
   logic [9:0] SW       = '0;
   logic [4:0] LEDR;
   logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

   int n_cmp = 0;
   int n_err = 0;

   logic [6:0] seg_tab [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   adder_top dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .SW       (SW),
      .LEDR     (LEDR),
      .HEX0     (HEX0),
      .HEX1     (HEX1),
      .HEX2     (HEX2),
      .HEX3     (HEX3),
      .HEX4     (HEX4),
      .HEX5     (HEX5)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // A - B as a 5-bit value is A - B + 16 (carry set when no borrow)
   function automatic logic [4:0] ref_led(input logic [9:0] sw);
      int a, b, r;
      a = int'(sw[7:4]);
      b = int'(sw[3:0]);
      if (sw[9]) r = a - b + 16;
      else       r = a + b + int'(sw[8]);
      return 5'(r);
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_model(input string tag, input logic [9:0] sw);
      logic [4:0] e;
      e = ref_led(sw);
      chk({tag, ".led"},  8'(LEDR), 8'(e));
      chk({tag, ".hex0"}, 8'(HEX0), 8'(seg_tab[sw[3:0]]));
      chk({tag, ".hex1"}, 8'(HEX1), 8'(seg_tab[sw[7:4]]));
      chk({tag, ".hex2"}, 8'(HEX2), 8'(seg_tab[e[3:0]]));
      chk({tag, ".hex3"}, 8'(HEX3), 8'(seg_tab[{3'b000, e[4]}]));
      chk({tag, ".hex4"}, 8'(HEX4), 8'h7F);
      chk({tag, ".hex5"}, 8'(HEX5), 8'h7F);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".led"},  8'(LEDR), 8'h00);
      chk({tag, ".hex0"}, 8'(HEX0), 8'h40);
      chk({tag, ".hex1"}, 8'(HEX1), 8'h40);
      chk({tag, ".hex2"}, 8'(HEX2), 8'h40);
      chk({tag, ".hex3"}, 8'(HEX3), 8'h40);
      chk({tag, ".hex4"}, 8'(HEX4), 8'h7F);
      chk({tag, ".hex5"}, 8'(HEX5), 8'h7F);
   endtask

   task automatic step(input logic [9:0] sw, input logic rst);
      @(negedge CLOCK_50);
      SW    = sw;
      reset = rst;
      @(posedge CLOCK_50);
      #1;
   endtask

   initial begin
      logic [9:0] sw_r;

      step(10'h3FF, 1'b1);
      chk_reset("rst1");
      step(10'h3FF, 1'b1);
      chk_reset("rst2");
      step(10'h0FF | 10'h100, 1'b0);
      chk("rel_max", 8'(LEDR), 8'h1F);
      chk_model("rel", 10'h1FF);

      step(10'b0_0_0101_0011, 1'b0);
      chk("add53.led", 8'(LEDR), 8'h08);
      chk("add53.hex1", 8'(HEX1), 8'h12);
      chk("add53.hex0", 8'(HEX0), 8'h30);
      chk("add53.hex2", 8'(HEX2), 8'h00);
      chk("add53.hex3", 8'(HEX3), 8'h40);
      step(10'b0_1_0101_0011, 1'b0);
      chk("add53c.led", 8'(LEDR), 8'h09);

      step(10'b0_0_1001_1000, 1'b0);
      chk("add98.led", 8'(LEDR), 8'h11);
      chk("add98.hex3", 8'(HEX3), 8'h79);
      chk("add98.hex2", 8'(HEX2), 8'h79);

      step(10'b1_0_0101_0011, 1'b0);
      chk("sub53.led", 8'(LEDR), 8'h12);
      step(10'b1_0_0011_0101, 1'b0);
      chk("sub35.led", 8'(LEDR), 8'h0E);
      step(10'b1_1_0111_0111, 1'b0);
      chk("sub77.led", 8'(LEDR), 8'h10);
      step(10'b1_0_0000_1111, 1'b0);
      chk("sub0f.led", 8'(LEDR), 8'h01);

      // inputs wiggled between edges must not reach the outputs
      step(10'h2A5, 1'b0);
      chk_model("lat0", 10'h2A5);
      @(negedge CLOCK_50);
      SW = 10'h137;
      #1;
      chk("lat_hold1", 8'(LEDR), 8'(ref_led(10'h2A5)));
      SW = 10'h3C1;
      #1;
      chk("lat_hold2", 8'(LEDR), 8'(ref_led(10'h2A5)));
      SW = 10'h05E;
      @(posedge CLOCK_50);
      #1;
      chk_model("lat1", 10'h05E);

      step(10'h1F3, 1'b1);
      chk_reset("midrst");
      step(10'h1F3, 1'b0);
      chk_model("midrst_rel", 10'h1F3);

      for (int i = 0; i < 1024; i++) begin
         step(10'(i), 1'b0);
         chk_model("exh", 10'(i));
      end

      for (int i = 0; i < 200; i++) begin
         sw_r = 10'($urandom);
         step(sw_r, 1'b0);
         chk_model("rnd", sw_r);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end
endmodule
